// File: rtl/model_link_buffer.sv
// Two-entry skid buffer between two model stages. s_ready is registered so the upstream never
// sees a combinational path from m_ready; lane 1 can optionally be index-mirrored on the way in.
module model_link_buffer #(
   parameter string       REVERSE = "FALSE",
   parameter int unsigned CNT_W   = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [2:-2]      s_d0,
   input  logic [-2:2]      s_d1,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [2:-2]      m_d0,
   output logic [-2:2]      m_d1,
   output logic [1:0]       level,
   output logic [CNT_W-1:0] xfer_cnt
);

   if (!(REVERSE == "FALSE" || REVERSE == "TRUE")) begin : gen_bad_reverse
      $error("model_link_buffer: REVERSE must be \"TRUE\" or \"FALSE\"");
   end
   if (CNT_W < 1 || CNT_W > 32) begin : gen_bad_cnt_w
      $error("model_link_buffer: CNT_W must be in 1..32");
   end

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [2:-2]      main_d0_q, main_d0_d, skid_d0_q, skid_d0_d;
   logic [-2:2]      main_d1_q, main_d1_d, skid_d1_q, skid_d1_d;
   logic             s_ready_q, s_ready_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [-2:2]      s_d1_map;
   logic             push, pop;

   // Mapping is applied on entry so both registers hold words already in output order.
   if (REVERSE == "TRUE") begin : gen_mirror
      for (genvar k = -2; k <= 2; k++) begin : gen_bit
         assign s_d1_map[k] = s_d1[-k];
      end
   end else begin : gen_straight
      assign s_d1_map = s_d1;
   end

   assign push = s_valid & s_ready_q;
   assign pop  = m_valid & m_ready;

   always_comb begin
      state_d   = state_q;
      main_d0_d = main_d0_q;
      main_d1_d = main_d1_q;
      skid_d0_d = skid_d0_q;
      skid_d1_d = skid_d1_q;
      unique case (state_q)
         StEmpty: begin
            if (push) begin
               main_d0_d = s_d0;
               main_d1_d = s_d1_map;
               state_d   = StOne;
            end
         end
         StOne: begin
            if (push && pop) begin
               main_d0_d = s_d0;
               main_d1_d = s_d1_map;
            end else if (push) begin
               skid_d0_d = s_d0;
               skid_d1_d = s_d1_map;
               state_d   = StTwo;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            if (pop) begin
               main_d0_d = skid_d0_q;
               main_d1_d = skid_d1_q;
               state_d   = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
      s_ready_d = (state_d != StTwo);
      cnt_d     = cnt_q + CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StEmpty;
         main_d0_q <= '0;
         main_d1_q <= '0;
         skid_d0_q <= '0;
         skid_d1_q <= '0;
         s_ready_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         main_d0_q <= main_d0_d;
         main_d1_q <= main_d1_d;
         skid_d0_q <= skid_d0_d;
         skid_d1_q <= skid_d1_d;
         s_ready_q <= s_ready_d;
         cnt_q     <= cnt_d;
      end
   end

   assign s_ready  = s_ready_q;
   assign m_valid  = (state_q != StEmpty);
   assign level    = state_q;
   assign m_d0     = main_d0_q;
   assign m_d1     = main_d1_q;
   assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_model_link_buffer.sv
// Bench for model_link_buffer: a straight/10-bit and a mirrored/2-bit instance share stimulus and
// are compared every cycle against a queue-based model of the buffer.
module tb_model_link_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, s_valid, m_ready;
   logic [2:-2] s_d0;
   logic [-2:2] s_d1;

   logic        sr_a, mv_a, sr_b, mv_b;
   logic [2:-2] md0_a, md0_b;
   logic [-2:2] md1_a, md1_b;
   logic [1:0]  lvl_a, lvl_b;
   logic [9:0]  cnt_a;
   logic [1:0]  cnt_b;

   model_link_buffer #(.REVERSE("FALSE"), .CNT_W(10)) dut_a (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr_a), .s_d0(s_d0), .s_d1(s_d1),
      .m_valid(mv_a), .m_ready(m_ready), .m_d0(md0_a), .m_d1(md1_a), .level(lvl_a),
      .xfer_cnt(cnt_a)
   );

   model_link_buffer #(.REVERSE("TRUE"), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr_b), .s_d0(s_d0), .s_d1(s_d1),
      .m_valid(mv_b), .m_ready(m_ready), .m_d0(md0_b), .m_d1(md1_b), .level(lvl_b),
      .xfer_cnt(cnt_b)
   );

   typedef struct packed {
      logic [4:0] d0;
      logic [4:0] d1;
   } word_t;

   word_t       mdl_q[$];
   logic [4:0]  disp_d0, disp_d1;
   bit          mdl_ready;
   int unsigned n_xfer;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [4:0] mirror(input logic [4:0] v);
      logic [4:0] r;
      for (int i = 0; i < 5; i++) r[i] = v[4-i];
      return r;
   endfunction

   task automatic check_all();
      logic [4:0] got_d0_a, got_d1_a, got_d0_b, got_d1_b;
      got_d0_a = md0_a;
      got_d1_a = md1_a;
      got_d0_b = md0_b;
      got_d1_b = md1_b;
      check("a_valid", 32'(mv_a), 32'(mdl_q.size() > 0));
      check("a_level", 32'(lvl_a), 32'(mdl_q.size()));
      check("a_ready", 32'(sr_a), 32'(mdl_ready));
      check("a_d0", 32'(got_d0_a), 32'(disp_d0));
      check("a_d1", 32'(got_d1_a), 32'(disp_d1));
      check("a_cnt", 32'(cnt_a), n_xfer % 1024);
      check("b_valid", 32'(mv_b), 32'(mdl_q.size() > 0));
      check("b_level", 32'(lvl_b), 32'(mdl_q.size()));
      check("b_ready", 32'(sr_b), 32'(mdl_ready));
      check("b_d0", 32'(got_d0_b), 32'(disp_d0));
      check("b_d1", 32'(got_d1_b), 32'(mirror(disp_d1)));
      check("b_cnt", 32'(cnt_b), n_xfer % 4);
   endtask

   // One clock: update the model from the inputs seen at the edge, then compare.
   task automatic step();
      bit    push, pop;
      word_t w;
      @(posedge clk);
      if (rst) begin
         mdl_q.delete();
         disp_d0   = '0;
         disp_d1   = '0;
         mdl_ready = 1'b0;
         n_xfer    = 0;
      end else begin
         pop  = (mdl_q.size() > 0) && m_ready;
         push = s_valid && mdl_ready;
         if (pop) begin
            void'(mdl_q.pop_front());
            n_xfer++;
         end
         if (push) begin
            w.d0 = s_d0;
            w.d1 = s_d1;
            mdl_q.push_back(w);
         end
         if (mdl_q.size() > 0) begin
            disp_d0 = mdl_q[0].d0;
            disp_d1 = mdl_q[0].d1;
         end
         mdl_ready = (mdl_q.size() < 2);
      end
      #1;
      check_all();
   endtask

   task automatic drive(input bit v, input bit r, input logic [4:0] a, input logic [4:0] b);
      s_valid = v;
      m_ready = r;
      s_d0    = a;
      s_d1    = b;
   endtask

   initial begin
      logic [4:0] tmp;
      rst = 1'b1;
      drive(0, 0, 5'd0, 5'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // Single word pushed with m_ready already high.
      drive(1, 1, 5'b10110, 5'b00011);
      step();
      check("single_d0", 32'(md0_a), 32'(5'b10110));
      drive(0, 1, 5'd0, 5'd0);
      step();
      check("single_cnt", 32'(cnt_a), 32'd1);
      step();

      // Backpressure: fill, attempt a third push, then drain.
      drive(1, 0, 5'h0a, 5'h11);
      step();
      drive(1, 0, 5'h0b, 5'h12);
      step();
      check("bp_level", 32'(lvl_a), 32'd2);
      drive(1, 0, 5'h0c, 5'h13);
      step();
      drive(0, 1, 5'd0, 5'd0);
      repeat (3) step();

      // Streaming from a fresh reset.
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      for (int i = 0; i < 20; i++) begin
         tmp = 5'(i);
         drive(1, 1, tmp, ~tmp);
         step();
      end
      drive(0, 1, 5'd0, 5'd0);
      repeat (2) step();
      check("stream_cnt", 32'(cnt_a), 32'd20);

      // Single set bit on lane 1 to expose the mirroring.
      drive(1, 1, 5'd0, 5'b10000);
      step();
      check("rev_bit", 32'(md1_b), 32'(5'b00001));
      drive(0, 0, 5'd0, 5'd0);
      step();

      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0),
               5'($urandom()), 5'($urandom()));
         step();
      end

      // Reset while full discards both entries.
      rst = 1'b1;
      drive(0, 0, 5'd0, 5'd0);
      step();
      rst = 1'b0;
      step();
      drive(1, 0, 5'h15, 5'h0e);
      step();
      drive(1, 0, 5'h1f, 5'h1f);
      step();
      check("full_level", 32'(lvl_b), 32'd2);
      rst = 1'b1;
      drive(1, 1, 5'h1f, 5'h1f);
      step();
      rst = 1'b0;
      drive(0, 0, 5'd0, 5'd0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
